// File: rtl/div_share_sched.sv
// Shares one sequential rounding divider between N_REQ requesters (accept, start, wait, respond).
// Macro DIV_SHARE_RR_EN: defined = rotating round-robin arbitration, undefined = fixed lowest-index priority.
module div_share_sched #(
    parameter int N_REQ   = 4,
    parameter int Z_L     = 32,
    parameter int D_L     = 17,
    parameter int TIMEOUT = 63
) (
    input  logic                     Clk_i,
    input  logic                     Rst_n_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*Z_L-1:0]     req_z_i,
    input  logic [N_REQ*D_L-1:0]     req_d_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [Z_L-D_L:0]         rsp_q_o,
    output logic [$clog2(N_REQ)-1:0] rsp_id_o,
    output logic                     rsp_err_o,
    output logic                     div_start_o,
    output logic [Z_L-1:0]           div_z_o,
    output logic [D_L-1:0]           div_d_o,
    input  logic [Z_L-D_L:0]         div_q_i,
    input  logic                     div_finish_i
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    grant;
    logic             grant_vld;
    logic             accept;
    logic [Z_L-1:0]   sel_z, z_q;
    logic [D_L-1:0]   sel_d, d_q;
    logic [CW-1:0]    cnt;
    logic [Z_L-D_L:0] q_q;
    logic [IW-1:0]    id_q;
    logic             err_q;

`ifdef DIV_SHARE_RR_EN
    logic [IW-1:0] ptr;
    logic [IW:0]   slot;
    logic [IW:0]   ptr_inc;

    // Search starts at the pointer and wraps upward; first valid slot wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        slot      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(N_REQ))
                slot = slot - (IW+1)'(N_REQ);
            if (!grant_vld && req_valid_i[slot[IW-1:0]]) begin
                grant_vld = 1'b1;
                grant     = slot[IW-1:0];
            end
        end
    end

    assign ptr_inc = {1'b0, grant} + (IW+1)'(1);

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i)
            ptr <= '0;
        else if (accept)
            ptr <= (ptr_inc >= (IW+1)'(N_REQ)) ? '0 : ptr_inc[IW-1:0];
    end
`else
    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = IW'(k);
            if (!grant_vld && req_valid_i[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end
`endif

    always_comb begin
        sel_z = '0;
        sel_d = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant == IW'(k)) begin
                sel_z = req_z_i[k*Z_L +: Z_L];
                sel_d = req_d_i[k*D_L +: D_L];
            end
        end
    end

    // Acceptance is masked during reset so req_ready_o reads 0 while Rst_n_i is low.
    assign accept = Rst_n_i && grant_vld && (state == IDLE);

    always_comb begin
        req_ready_o = '0;
        if (accept)
            req_ready_o[grant] = 1'b1;
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = (sel_d == '0) ? RESP : START;
            START: state_nxt = WAIT;
            WAIT:  if (div_finish_i || cnt == TMAX) state_nxt = RESP;
            RESP:  if (rsp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            z_q   <= '0;
            d_q   <= '0;
            cnt   <= '0;
            q_q   <= '0;
            id_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                z_q  <= sel_z;
                d_q  <= sel_d;
                id_q <= grant;
                if (sel_d == '0) begin
                    q_q   <= '1;
                    err_q <= 1'b1;
                end
            end
            if (state == START)
                cnt <= '0;
            if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (div_finish_i) begin
                    q_q   <= div_q_i;
                    err_q <= 1'b0;
                end else if (cnt == TMAX) begin
                    q_q   <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign div_start_o = (state == START);
    assign div_z_o     = z_q;
    assign div_d_o     = d_q;
    assign rsp_valid_o = (state == RESP);
    assign rsp_q_o     = q_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a behavioural 21-cycle round-to-nearest divider model.
module tb_div_share_sched;
    localparam int N   = 4;
    localparam int ZL  = 32;
    localparam int DL  = 17;
    localparam int TO  = 63;
    localparam int QW  = ZL - DL + 1;
    localparam int LAT = 21;

    logic            Clk_i = 1'b0;
    logic            Rst_n_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*ZL-1:0] req_z_i;
    logic [N*DL-1:0] req_d_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [QW-1:0]   rsp_q_o;
    logic [1:0]      rsp_id_o;
    logic            rsp_err_o;
    logic            div_start_o;
    logic [ZL-1:0]   div_z_o;
    logic [DL-1:0]   div_d_o;
    logic [QW-1:0]   div_q_i = '0;
    logic            div_finish_i = 1'b0;

    int checks = 0;
    int errors = 0;

    div_share_sched #(.N_REQ(N), .Z_L(ZL), .D_L(DL), .TIMEOUT(TO)) dut (
        .Clk_i(Clk_i), .Rst_n_i(Rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_z_i(req_z_i), .req_d_i(req_d_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_q_o(rsp_q_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o),
        .div_start_o(div_start_o), .div_z_o(div_z_o), .div_d_o(div_d_o),
        .div_q_i(div_q_i), .div_finish_i(div_finish_i)
    );

    always #5 Clk_i = ~Clk_i;

    // Divider model: finish 21 cycles after the start cycle; not reset, so a late finish can follow a DUT reset.
    logic          stuck = 1'b0;
    logic          mbusy = 1'b0;
    int            mcnt  = 0;
    logic [ZL-1:0] mz = '0;
    logic [DL-1:0] md = '0;
    always @(posedge Clk_i) begin
        div_finish_i <= 1'b0;
        if (div_start_o && !stuck) begin
            mz    <= div_z_o;
            md    <= div_d_o;
            mcnt  <= LAT - 1;
            mbusy <= 1'b1;
        end else if (mbusy) begin
            if (mcnt == 1) begin
                div_finish_i <= 1'b1;
                div_q_i      <= QW'((64'(mz) + 64'(md / 2)) / 64'(md));
                mbusy        <= 1'b0;
            end
            mcnt <= mcnt - 1;
        end
    end

    task automatic tick;
        @(posedge Clk_i);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ZL-1:0] z, input logic [DL-1:0] d);
        req_z_i[i*ZL +: ZL] = z;
        req_d_i[i*DL +: DL] = d;
    endtask

    // Issue one request from IDLE; latency is counted in cycles from the acceptance cycle.
    task automatic run_op(input int id, input logic [ZL-1:0] z, input logic [DL-1:0] d,
                          output logic [N-1:0] rdy, output int starts, output logic s1,
                          output int lat, output logic [QW-1:0] q, output logic [1:0] rid,
                          output logic err);
        set_req(id, z, d);
        req_valid_i[id] = 1'b1;
        #1;
        rdy    = req_ready_o;
        starts = 0;
        s1     = 1'b0;
        lat    = -1;
        for (int n = 1; n <= 200; n++) begin
            tick;
            if (n == 1) begin
                req_valid_i = '0;
                s1 = div_start_o;
            end
            if (div_start_o) starts++;
            if (rsp_valid_o) begin
                lat = n;
                break;
            end
        end
        q   = rsp_q_o;
        rid = rsp_id_o;
        err = rsp_err_o;
        if (lat > 0) tick;
    endtask

    task automatic test_reset;
        Rst_n_i     = 1'b0;
        rsp_ready_i = 1'b1;
        req_valid_i = '1;
        for (int i = 0; i < N; i++) set_req(i, ZL'(i + 5), DL'(i + 1));
        tick; tick;
        checks++; if (req_ready_o !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++; if (rsp_q_o !== '0) begin errors++; $display("FAIL reset_rsp_q: got %h expected 0", rsp_q_o); end
        checks++; if (rsp_id_o !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id_o); end
        checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err_o); end
        checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", div_start_o); end
        checks++; if (div_z_o !== '0 || div_d_o !== '0) begin errors++; $display("FAIL reset_div_ops: got z=%h d=%h expected 0 0", div_z_o, div_d_o); end
        req_valid_i = '0;
        tick;
        Rst_n_i = 1'b1;
        tick;
    endtask

    task automatic test_single;
        logic [N-1:0] rdy; int st; logic s1; int lat; logic [QW-1:0] q; logic [1:0] rid; logic err;
        run_op(2, 32'd1000, 17'd7, rdy, st, s1, lat, q, rid, err);
        checks++; if (rdy !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", rdy); end
        checks++; if (s1 !== 1'b1 || st !== 1) begin errors++; $display("FAIL single_start: got c1=%b count=%0d expected 1 1", s1, st); end
        checks++; if (lat !== 23) begin errors++; $display("FAIL single_latency: got %0d expected 23", lat); end
        checks++; if (q !== 16'd143) begin errors++; $display("FAIL single_q: got %0d expected 143", q); end
        checks++; if (rid !== 2'd2) begin errors++; $display("FAIL single_id: got %0d expected 2", rid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
        checks++; if (div_z_o !== 32'd1000 || div_d_o !== 17'd7) begin errors++; $display("FAIL single_div_ops: got z=%0d d=%0d expected 1000 7", div_z_o, div_d_o); end
    endtask

    task automatic test_rounding;
        logic [N-1:0] rdy; int st; logic s1; int lat; logic [QW-1:0] q; logic [1:0] rid; logic err;
        run_op(0, 32'd10, 17'd4, rdy, st, s1, lat, q, rid, err);
        checks++; if (q !== 16'd3 || err !== 1'b0) begin errors++; $display("FAIL round_10_4: got q=%0d err=%b expected 3 0", q, err); end
        checks++; if (rdy !== 4'b0001 || rid !== 2'd0) begin errors++; $display("FAIL round_10_4_id: got ready=%b id=%0d expected 0001 0", rdy, rid); end
        run_op(1, 32'd9, 17'd4, rdy, st, s1, lat, q, rid, err);
        checks++; if (q !== 16'd2 || err !== 1'b0) begin errors++; $display("FAIL round_9_4: got q=%0d err=%b expected 2 0", q, err); end
        checks++; if (lat !== 23) begin errors++; $display("FAIL round_9_4_latency: got %0d expected 23", lat); end
    endtask

    task automatic test_div_zero;
        logic [N-1:0] rdy; int st; logic s1; int lat; logic [QW-1:0] q; logic [1:0] rid; logic err;
        run_op(1, 32'd5, 17'd0, rdy, st, s1, lat, q, rid, err);
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        checks++; if (st !== 0) begin errors++; $display("FAIL div0_no_start: got %0d starts expected 0", st); end
        checks++; if (q !== 16'hFFFF || err !== 1'b1) begin errors++; $display("FAIL div0_q_err: got q=%h err=%b expected ffff 1", q, err); end
        checks++; if (rid !== 2'd1) begin errors++; $display("FAIL div0_id: got %0d expected 1", rid); end
        for (int n = 0; n < 3; n++) tick;
        checks++; if (mbusy !== 1'b0 || div_start_o !== 1'b0) begin errors++; $display("FAIL div0_divider_idle: got busy=%b start=%b expected 0 0", mbusy, div_start_o); end
    endtask

    task automatic test_contention;
`ifdef DIV_SHARE_RR_EN
        localparam int NG = 5;
`else
        localparam int NG = 3;
`endif
        int order[NG];
        int g = 0;
        int exp_g;
        Rst_n_i = 1'b0;
        tick;
        Rst_n_i = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, ZL'(100 + i), DL'(i + 2));
        req_valid_i = '1;
        #1;
        for (int n = 0; n < 400 && g < NG; n++) begin
            if (req_ready_o != '0) begin
                for (int b = 0; b < N; b++) if (req_ready_o[b]) order[g] = b;
                g++;
            end
            tick;
        end
        req_valid_i = '0;
        checks++; if (g !== NG) begin errors++; $display("FAIL contention_count: got %0d grants expected %0d", g, NG); end
        for (int k = 0; k < g; k++) begin
`ifdef DIV_SHARE_RR_EN
            exp_g = k % N;
`else
            exp_g = 0;
`endif
            checks++; if (order[k] !== exp_g) begin errors++; $display("FAIL contention_grant%0d: got %0d expected %0d", k, order[k], exp_g); end
        end
        for (int n = 0; n < 100 && !rsp_valid_o; n++) tick;
        tick;
    endtask

    task automatic test_backpressure;
        rsp_ready_i = 1'b0;
        set_req(3, 32'd100, 17'd3);
        req_valid_i[3] = 1'b1;
        #1;
        tick;
        req_valid_i = '0;
        set_req(0, 32'd50, 17'd5);
        req_valid_i[0] = 1'b1;
        for (int n = 0; n < 100 && !rsp_valid_o; n++) tick;
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_response: got valid=%b expected 1", rsp_valid_o); end
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_q_o !== 16'd33 || rsp_id_o !== 2'd3 || rsp_err_o !== 1'b0 || req_ready_o !== '0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b q=%0d id=%0d err=%b rdy=%b expected 1 33 3 0 0000",
                         n, rsp_valid_o, rsp_q_o, rsp_id_o, rsp_err_o, req_ready_o);
            end
            tick;
        end
        rsp_ready_i = 1'b1;
        tick;
        checks++; if (req_ready_o !== 4'b0001 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_next_grant: got rdy=%b v=%b expected 0001 0", req_ready_o, rsp_valid_o); end
        tick;
        req_valid_i = '0;
        for (int n = 0; n < 100 && !rsp_valid_o; n++) tick;
        checks++; if (rsp_q_o !== 16'd10 || rsp_id_o !== 2'd0) begin errors++; $display("FAIL bp_second_rsp: got q=%0d id=%0d expected 10 0", rsp_q_o, rsp_id_o); end
        tick;
    endtask

    task automatic test_timeout;
        logic [N-1:0] rdy; int st; logic s1; int lat; logic [QW-1:0] q; logic [1:0] rid; logic err;
        stuck = 1'b1;
        run_op(2, 32'd77, 17'd5, rdy, st, s1, lat, q, rid, err);
        stuck = 1'b0;
        checks++; if (lat !== 2 + TO + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, 2 + TO + 1); end
        checks++; if (q !== '0 || err !== 1'b1) begin errors++; $display("FAIL timeout_q_err: got q=%0d err=%b expected 0 1", q, err); end
        checks++; if (rid !== 2'd2 || st !== 1) begin errors++; $display("FAIL timeout_id_start: got id=%0d starts=%0d expected 2 1", rid, st); end
    endtask

    task automatic test_reset_wait;
        logic [N-1:0] rdy; int st; logic s1; int lat; logic [QW-1:0] q; logic [1:0] rid; logic err;
        int spurious = 0;
        set_req(1, 32'd20, 17'd3);
        req_valid_i[1] = 1'b1;
        #1;
        tick;
        req_valid_i = '0;
        for (int n = 0; n < 4; n++) tick;
        Rst_n_i = 1'b0;
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || div_start_o !== 1'b0 || div_z_o !== '0 || div_d_o !== '0 ||
            rsp_q_o !== '0 || rsp_id_o !== '0 || rsp_err_o !== 1'b0 || req_ready_o !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs: got v=%b st=%b z=%0d d=%0d q=%0d id=%0d err=%b rdy=%b expected all 0",
                     rsp_valid_o, div_start_o, div_z_o, div_d_o, rsp_q_o, rsp_id_o, rsp_err_o, req_ready_o);
        end
        tick;
        Rst_n_i = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick;
            if (rsp_valid_o || div_start_o) spurious++;
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL rstwait_late_finish: got %0d active cycles expected 0", spurious); end
        run_op(0, 32'd21, 17'd2, rdy, st, s1, lat, q, rid, err);
        checks++; if (lat !== 23 || q !== 16'd11 || err !== 1'b0 || rid !== 2'd0) begin errors++; $display("FAIL rstwait_next_op: got lat=%0d q=%0d err=%b id=%0d expected 23 11 0 0", lat, q, err, rid); end
    endtask

    initial begin
        req_valid_i = '0;
        req_z_i     = '0;
        req_d_i     = '0;
        rsp_ready_i = 1'b1;
        test_reset;
        test_single;
        test_rounding;
        test_div_zero;
        test_contention;
        test_backpressure;
        test_timeout;
        test_reset_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
